sample_mem_arbiter: RTL and testbench

//  Shares the single-port 8x8 sample memory (64 words) between the host loader and the DCT

---
 rtl/sample_mem_pkg.sv | 20 ++
 rtl/sat_counter.sv | 33 +++
 rtl/sample_mem_arbiter.sv | 129 ++++++++++++
 tb/tb_sample_mem_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sample_mem_pkg.sv
// rtl/sample_mem_pkg.sv - shared types and sizes for the sample memory arbiter
package sample_mem_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;

  // IDLE: host owns the RAM; LOCK: a DCT frame is in progress
  typedef enum logic {
    IDLE,
    LOCK
  } state_e;

  // Owner of the read issued last cycle; routes Mem_RData to the right port
  typedef enum logic [1:0] {
    NONE,
    HOST,
    DCT
  } tag_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         clear_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Increment unless already at all-ones
  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register; clear has priority
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/sample_mem_arbiter.sv
// rtl/sample_mem_arbiter.sv - host/DCT arbiter for the 64-word sample RAM (option: HOST_READ_DURING_LOCK_EN)
module sample_mem_arbiter #(
  parameter int ADDR_W  = sample_mem_pkg::ADDR_W,
  parameter int DATA_W  = sample_mem_pkg::DATA_W,
  parameter int STALL_W = 16
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Ready,
  input  logic               Dct_Re,
  input  logic [ADDR_W-1:0]  Dct_Addr,
  output logic [DATA_W-1:0]  Dct_RData,
  output logic               Dct_RValid,
  input  logic               Host_Req,
  input  logic               Host_We,
  input  logic [ADDR_W-1:0]  Host_Addr,
  input  logic [DATA_W-1:0]  Host_WData,
  output logic               Host_Gnt,
  output logic [DATA_W-1:0]  Host_RData,
  output logic               Host_RValid,
  output logic               Locked,
  output logic [STALL_W-1:0] Host_Stall,
  output logic               Mem_En,
  output logic               Mem_We,
  output logic [ADDR_W-1:0]  Mem_Addr,
  output logic [DATA_W-1:0]  Mem_WData,
  input  logic [DATA_W-1:0]  Mem_RData
);

  import sample_mem_pkg::*;

  state_e            state_q;
  logic              ready_q;
  tag_e              tag_q;
  tag_e              tag_d;
  logic              dct_gnt;
  logic              host_gnt;
  logic [DATA_W-1:0] dct_hold_q;
  logic [DATA_W-1:0] host_hold_q;

  // Grant decision: DCT always wins; host only in IDLE (or reads in LOCK when enabled)
  always_comb begin
    dct_gnt  = Dct_Re && !Reset;
    host_gnt = 1'b0;
    if (!Reset && Host_Req && !Dct_Re) begin
      if (state_q == IDLE) begin
        host_gnt = 1'b1;
      end
`ifdef HOST_READ_DURING_LOCK_EN
      else if (!Host_We) begin
        host_gnt = 1'b1;
      end
`endif
    end
  end

  // RAM port mux and read-owner tag for next cycle
  always_comb begin
    Mem_En    = 1'b0;
    Mem_We    = 1'b0;
    Mem_Addr  = '0;
    Mem_WData = '0;
    tag_d     = NONE;
    if (dct_gnt) begin
      Mem_En   = 1'b1;
      Mem_Addr = Dct_Addr;
      tag_d    = DCT;
    end else if (host_gnt) begin
      Mem_En    = 1'b1;
      Mem_We    = Host_We;
      Mem_Addr  = Host_Addr;
      Mem_WData = Host_WData;
      tag_d     = Host_We ? NONE : HOST;
    end
  end

  // Frame FSM: lock on Start, release on a rising edge of Ready
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
    end else begin
      ready_q <= Ready;
      case (state_q)
        IDLE:    if (Start) state_q <= LOCK;
        LOCK:    if (Ready && !ready_q) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read tag; reset drops any in-flight read
  always_ff @(posedge Clock) begin
    if (Reset) begin
      tag_q <= NONE;
    end else begin
      tag_q <= tag_d;
    end
  end

  // Hold the last delivered word per port so RData is stable when RValid is low
  always_ff @(posedge Clock) begin
    if (Reset) begin
      dct_hold_q  <= '0;
      host_hold_q <= '0;
    end else begin
      if (tag_q == DCT)  dct_hold_q  <= Mem_RData;
      if (tag_q == HOST) host_hold_q <= Mem_RData;
    end
  end

  assign Dct_RValid  = (tag_q == DCT);
  assign Host_RValid = (tag_q == HOST);
  assign Dct_RData   = Dct_RValid  ? Mem_RData : dct_hold_q;
  assign Host_RData  = Host_RValid ? Mem_RData : host_hold_q;
  assign Host_Gnt    = host_gnt;
  assign Locked      = (state_q == LOCK);

  sat_counter #(
    .W(STALL_W)
  ) u_stall (
    .clk_i  (Clock),
    .clear_i(Reset),
    .inc_i  (Host_Req && !host_gnt),
    .count_o(Host_Stall)
  );

endmodule

// File: tb/tb_sample_mem_arbiter.sv
// tb/tb_sample_mem_arbiter.sv - randomized self-checking bench for sample_mem_arbiter
module tb_sample_mem_arbiter;

`ifdef HOST_READ_DURING_LOCK_EN
  localparam bit OPT = 1'b1;
`else
  localparam bit OPT = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        Reset, Start, Ready, Dct_Re, Host_Req, Host_We;
  logic [5:0]  Dct_Addr, Host_Addr, Mem_Addr;
  logic [7:0]  Host_WData, Dct_RData, Host_RData, Mem_WData, Mem_RData;
  logic        Dct_RValid, Host_Gnt, Host_RValid, Locked, Mem_En, Mem_We;
  logic [15:0] Host_Stall;

  always #5 Clock = ~Clock;

  sample_mem_arbiter dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Ready(Ready),
    .Dct_Re(Dct_Re), .Dct_Addr(Dct_Addr), .Dct_RData(Dct_RData), .Dct_RValid(Dct_RValid),
    .Host_Req(Host_Req), .Host_We(Host_We), .Host_Addr(Host_Addr), .Host_WData(Host_WData),
    .Host_Gnt(Host_Gnt), .Host_RData(Host_RData), .Host_RValid(Host_RValid),
    .Locked(Locked), .Host_Stall(Host_Stall),
    .Mem_En(Mem_En), .Mem_We(Mem_We), .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData),
    .Mem_RData(Mem_RData)
  );

  // Behavioural single-port RAM with 1-cycle synchronous read
  logic [7:0] ram [64];
  logic [7:0] ram_rdata = 8'h00;
  assign Mem_RData = ram_rdata;
  always @(posedge Clock) begin
    if (Mem_En) begin
      if (Mem_We) ram[Mem_Addr] <= Mem_WData;
      else        ram_rdata <= ram[Mem_Addr];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: frame lock flag, per-port delivered word, expected memory contents
  bit          chk_en = 1'b0;
  bit          m_locked = 1'b0, m_rprev = 1'b0, m_gnt = 1'b0;
  bit          m_dv = 1'b0, m_hv = 1'b0;
  logic [7:0]  m_dd = 8'h00, m_hd = 8'h00;
  logic [15:0] m_stall = 16'h0;
  logic [7:0]  mem_m [64];

  always @(negedge Clock) begin : model
    bit g, en;
    if (chk_en) begin
      g  = !Reset && Host_Req && !Dct_Re && (!m_locked || (OPT && !Host_We));
      en = !Reset && (Dct_Re || g);
      check_val("host_gnt", Host_Gnt, g);
      check_val("mem_en", Mem_En, en);
      check_val("mem_we", Mem_We, g && Host_We);
      if (en) check_val("mem_addr", Mem_Addr, Dct_Re ? Dct_Addr : Host_Addr);
      if (g && Host_We) check_val("mem_wdata", Mem_WData, Host_WData);
      check_val("locked", Locked, m_locked);
      check_val("dct_rvalid", Dct_RValid, m_dv);
      check_val("dct_rdata", Dct_RData, m_dd);
      check_val("host_rvalid", Host_RValid, m_hv);
      check_val("host_rdata", Host_RData, m_hd);
      check_val("host_stall", Host_Stall, m_stall);
      m_gnt = g;
      if (Reset) begin
        m_locked = 0; m_rprev = 0; m_dv = 0; m_hv = 0;
        m_dd = 0; m_hd = 0; m_stall = 0;
      end else begin
        m_dv = Dct_Re;
        if (Dct_Re) m_dd = mem_m[Dct_Addr];
        m_hv = g && !Host_We;
        if (g && !Host_We) m_hd = mem_m[Host_Addr];
        if (g && Host_We) mem_m[Host_Addr] = Host_WData;
        if (Host_Req && !g && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
        if (!m_locked && Start) m_locked = 1;
        else if (m_locked && Ready && !m_rprev) m_locked = 0;
        m_rprev = Ready;
      end
    end
  end

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic rand_step();
    Reset = ($urandom_range(0, 299) == 0);
    if (Reset) begin
      Host_Req = 1'b0;
    end else if (!(Host_Req && !m_gnt)) begin
      Host_Req   = ($urandom_range(0, 2) != 0);
      Host_We    = 1'($urandom_range(0, 1));
      Host_Addr  = 6'($urandom_range(0, 63));
      Host_WData = 8'($urandom_range(0, 255));
    end
    Start    = ($urandom_range(0, 19) == 0);
    Dct_Re   = ($urandom_range(0, 2) == 0);
    Dct_Addr = 6'($urandom_range(0, 63));
    Ready    = ($urandom_range(0, 14) == 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram[i]   = 8'h00;
      mem_m[i] = 8'h00;
    end
    Reset = 1; Start = 0; Ready = 0; Dct_Re = 0; Dct_Addr = 0;
    Host_Req = 0; Host_We = 0; Host_Addr = 0; Host_WData = 0;
    @(posedge Clock); #1;
    chk_en = 1;
    cyc();
    Reset = 0;

    // Host fills memory with addr*2 while idle
    for (int a = 0; a < 64; a++) begin
      Host_Req = 1; Host_We = 1; Host_Addr = 6'(a); Host_WData = 8'(a * 2);
      @(negedge Clock);
      check_val("t1_gnt", Host_Gnt, 1);
      cyc();
    end
    Host_Req = 0;
    @(negedge Clock);
    check_val("t1_stall", Host_Stall, 0);
    cyc();

    // Host read of address 5
    Host_Req = 1; Host_We = 0; Host_Addr = 6'd5;
    cyc();
    Host_Req = 0;
    @(negedge Clock);
    check_val("t2_rvalid", Host_RValid, 1);
    check_val("t2_rdata", Host_RData, 10);
    cyc();

    // DCT frame: Start then 8 reads
    Start = 1;
    cyc();
    Start = 0;
    for (int i = 0; i <= 8; i++) begin
      Dct_Re = (i < 8);
      Dct_Addr = 6'(i % 8);
      @(negedge Clock);
      check_val("t3_locked", Locked, 1);
      if (i > 0) begin
        check_val("t3_dvalid", Dct_RValid, 1);
        check_val("t3_ddata", Dct_RData, 2 * (i - 1));
      end
      cyc();
    end
    Dct_Re = 0;

    // Host write held off during the frame
    Host_Req = 1; Host_We = 1; Host_Addr = 6'd3; Host_WData = 8'h55;
    for (int w = 0; w < 5; w++) begin
      @(negedge Clock);
      check_val("t4_gnt_lock", Host_Gnt, 0);
      cyc();
    end
    Ready = 1;
    @(negedge Clock);
    check_val("t4_gnt_edge", Host_Gnt, 0);
    cyc();
    @(negedge Clock);
    check_val("t4_gnt_idle", Host_Gnt, 1);
    check_val("t4_stall", Host_Stall, 6);
    cyc();
    Host_Req = 0; Ready = 0;

    // Simultaneous DCT read and host read in IDLE
    Dct_Re = 1; Dct_Addr = 6'd7;
    Host_Req = 1; Host_We = 0; Host_Addr = 6'd3;
    @(negedge Clock);
    check_val("t5_gnt_first", Host_Gnt, 0);
    cyc();
    Dct_Re = 0;
    @(negedge Clock);
    check_val("t5_gnt_second", Host_Gnt, 1);
    check_val("t5_dvalid", Dct_RValid, 1);
    check_val("t5_ddata", Dct_RData, 14);
    cyc();
    Host_Req = 0;
    @(negedge Clock);
    check_val("t5_hvalid", Host_RValid, 1);
    check_val("t5_hdata", Host_RData, 8'h55);
    check_val("t5_dvalid_off", Dct_RValid, 0);
    cyc();

    // Host read inside a frame, then reset mid-frame with a read in flight
    Start = 1;
    cyc();
    Start = 0;
    Host_Req = 1; Host_We = 0; Host_Addr = 6'd5;
    @(negedge Clock);
    check_val("t6_lock_read", Host_Gnt, OPT);
    cyc();
    Host_Req = 0; Dct_Re = 1; Dct_Addr = 6'd2; Reset = 1;
    cyc();
    Reset = 0; Dct_Re = 0;
    @(negedge Clock);
    check_val("t6_locked", Locked, 0);
    check_val("t6_dvalid", Dct_RValid, 0);
    check_val("t6_hvalid", Host_RValid, 0);
    check_val("t6_ddata", Dct_RData, 0);
    check_val("t6_hdata", Host_RData, 0);
    check_val("t6_stall", Host_Stall, 0);
    cyc();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rand_step();
      cyc();
    end
    Reset = 0; Start = 0; Dct_Re = 0; Host_Req = 0; Ready = 0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
